// File: rtl/fft_ctrl.sv
// Sequencing controller for a radix-2 SDF FFT pipeline: frame FSM, step counter,
// per-stage butterfly/twiddle control. Define FFT_CTRL_BACKPRESSURE_EN to add out_ready.
module fft_ctrl #(
  parameter int N_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
`ifdef FFT_CTRL_BACKPRESSURE_EN
  input  logic                         out_ready,
`endif
  output logic                         in_ready,
  output logic                         adv,
  output logic [N_LOG2-1:0]            bf_en,
  output logic [N_LOG2*(N_LOG2-1)-1:0] tw_addr,
  output logic                         out_valid,
  output logic [N_LOG2-1:0]            out_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int N  = 1 << N_LOG2;
  localparam int KW = N_LOG2 + 1;
  localparam int TW = N_LOG2 - 1;
  localparam logic [KW-1:0] K_LOAD_END  = KW'(N - 1);
  localparam logic [KW-1:0] K_FLUSH_END = KW'(2*N - 2);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            ordy;
  logic [N_LOG2-1:0] oidx;

`ifdef FFT_CTRL_BACKPRESSURE_EN
  assign ordy = out_ready;
`else
  assign ordy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE:  if (start) begin
               state_d = LOAD;
               k_d     = '0;
             end
      LOAD:  if (adv) begin
               k_d = k_q + 1'b1;
               if (k_q == K_LOAD_END) state_d = FLUSH;
             end
      FLUSH: if (adv) begin
               k_d = k_q + 1'b1;
               if (k_q == K_FLUSH_END) state_d = DONE;
             end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while rst_n is asserted, not just after the edge.
  always_comb begin
    in_ready = 1'b0;
    adv      = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (rst_n) begin
      case (state_q)
        LOAD: begin
          busy     = 1'b1;
          in_ready = ordy | (k_q < K_LOAD_END);
          adv      = in_valid & in_ready;
        end
        FLUSH: begin
          busy = 1'b1;
          adv  = ordy;
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end

  // Stage s sees sample index j_s = k - D_s; the extra MSB of dif flags j_s < 0.
  for (genvar s = 0; s < N_LOG2; s++) begin : g_stage
    localparam int JW = N_LOG2 - s;
    localparam logic [KW:0] D = (KW+1)'(N - (1 << (N_LOG2 - s)));
    logic [KW:0] dif;
    logic        act;
    assign dif = {1'b0, k_q} - D;
    assign act = busy & ~dif[KW] & (dif[KW-1:0] <= K_LOAD_END);
    assign bf_en[s] = adv & act & dif[JW-1];
    if (s == N_LOG2 - 1) begin : g_last
      assign tw_addr[s*TW +: TW] = '0;
    end else begin : g_tw
      assign tw_addr[s*TW +: TW] = act ? (TW'(dif[JW-2:0]) << s) : '0;
    end
  end

  assign out_valid = adv & (k_q >= K_LOAD_END);
  assign oidx      = N_LOG2'(k_q - K_LOAD_END);

  always_comb begin
    out_idx = '0;
    if (out_valid)
      for (int i = 0; i < N_LOG2; i++) out_idx[i] = oidx[N_LOG2-1-i];
  end

endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl (N_LOG2=4): per-advance expectations queued by stimulus,
// popped by a negedge monitor; frame timing checked directly by the stimulus.
module tb_fft_ctrl;
  localparam int NL = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
`ifdef FFT_CTRL_BACKPRESSURE_EN
  logic out_ready = 1'b1;
`endif
  logic              in_ready, adv, out_valid, busy, done;
  logic [NL-1:0]     bf_en, out_idx;
  logic [NL*(NL-1)-1:0] tw_addr;

  fft_ctrl #(.N_LOG2(NL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
`ifdef FFT_CTRL_BACKPRESSURE_EN
    .out_ready(out_ready),
`endif
    .in_ready(in_ready), .adv(adv), .bf_en(bf_en), .tw_addr(tw_addr),
    .out_valid(out_valid), .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  bf;
    logic [11:0] tw;
    logic        ov;
    logic [3:0]  idx;
  } exp_t;

  exp_t q[$];
  int nvec = 0, nerr = 0;
  logic [30:0] m0, m1, m2, m3;
  int ridx[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_tw(input int k);
    int f0, f1, f2;
    f0 = (k <= 15) ? k % 8 : 0;
    f1 = (k >= 8  && k <= 23) ? ((k - 8) % 4) * 2 : 0;
    f2 = (k >= 12 && k <= 27) ? ((k - 12) % 2) * 4 : 0;
    return {3'b000, f2[2:0], f1[2:0], f0[2:0]};
  endfunction

  task automatic push_frame(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.bf  = {m3[k], m2[k], m1[k], m0[k]};
      e.tw  = exp_tw(k);
      e.ov  = (k >= 15);
      e.idx = e.ov ? 4'(ridx[k-15]) : 4'd0;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (adv) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL sb_underflow: adv with no expectation at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("bf_en", 32'(bf_en), 32'(e.bf));
          chk("tw_addr", 32'(tw_addr), 32'(e.tw));
          chk("out_valid", 32'(out_valid), 32'(e.ov));
          chk("out_idx", 32'(out_idx), 32'(e.idx));
        end
      end else if (busy) begin
        chk("bubble_quiet", {23'd0, bf_en, out_valid, out_idx}, 32'd0);
      end
    end
  end

  // mode: 0 plain, 1 in_valid toggling, 2 start/in_valid poked in FLUSH, 3 backpressure
  task automatic run_frame(input int mode, input int exp_done);
    int p, nrdy, nadv;
    bit seen;
    push_frame(31);
    start = 1'b1; in_valid = 1'b1;
    p = 0; nrdy = 0; nadv = 0; seen = 1'b0;
    while (p < 200 && !seen) begin
      @(posedge clk); #1; p++;
      start    = 1'b0;
      in_valid = (mode == 1) ? p[0] : 1'b1;
      if (mode == 2 && p >= 20 && p <= 24) start = 1'b1;
`ifdef FFT_CTRL_BACKPRESSURE_EN
      out_ready = !(mode == 3 && p >= 19 && p <= 21);
`endif
      @(negedge clk);
      if (in_ready) nrdy++;
      if (adv) nadv++;
      if (mode == 2 && p >= 20 && p <= 24) chk("flush_in_ready", 32'(in_ready), 32'd0);
      if (mode == 0 && p == 10) begin
        chk("k9_bf_en", 32'(bf_en), 32'b0001);
        chk("k9_tw0", 32'(tw_addr[2:0]), 32'd1);
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_cycle", p, exp_done);
    chk("adv_count", nadv, 31);
    chk("in_ready_cycles", nrdy, (mode == 1) ? 31 : 16);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_done", {7'd0, in_ready, adv, bf_en, tw_addr, out_valid, out_idx, busy, done}, 32'd0);
    chk("sb_drained", q.size(), 0);
  endtask

  initial begin
    m0 = 31'h0000FF00;
    m1 = 31'h00F0F000;
    m2 = 31'h0CCCC000;
    m3 = 31'h2AAA8000;
    ridx = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {7'd0, in_ready, adv, bf_en, tw_addr, out_valid, out_idx, busy, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {7'd0, in_ready, adv, bf_en, tw_addr, out_valid, out_idx, busy, done}, 32'd0);

    run_frame(0, 32);
    run_frame(1, 47);
    run_frame(2, 32);

    // Reset while k=20 in FLUSH, then a clean frame.
    push_frame(20);
    start = 1'b1; in_valid = 1'b1;
    for (int p = 1; p <= 21; p++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (p == 21) rst_n = 1'b0;
    end
    @(negedge clk);
    chk("rst_adv", 32'(adv), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", {27'd0, busy, out_valid, in_ready, adv, done}, 32'd0);
    chk("rst_sb_drained", q.size(), 0);
    run_frame(0, 32);

`ifdef FFT_CTRL_BACKPRESSURE_EN
    run_frame(3, 35);
`endif

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL provide parameter N_LOG2, default 4, giving log2 of the FFT length (N = 2^N_LOG2, legal range 2..10).
REQ-002 SHALL provide port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-003 SHALL provide port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL provide port start, input, 1, a frame start request, sampled only in IDLE.
REQ-005 SHALL provide port in_valid, input, 1, meaning an input sample is presented.
REQ-006 SHALL provide port in_ready, output, 1, meaning the controller accepts the sample this cycle.
REQ-007 SHALL provide port adv, output, 1, the pipeline advance strobe for all SDF stages and delay lines.
REQ-008 SHALL provide port bf_en, output, N_LOG2, the per-stage butterfly-mode select (bit s is stage s, stage 0 first).
REQ-009 SHALL provide port tw_addr, output, N_LOG2*(N_LOG2-1), the per-stage twiddle ROM address; field s is bits [s*(N_LOG2-1) +: N_LOG2-1].
REQ-010 SHALL provide port out_valid, output, 1, meaning the last stage presents a result this cycle.
REQ-011 SHALL provide port out_idx, output, N_LOG2, the natural-order frequency index of the current result.
REQ-012 SHALL provide ports busy and done, output, 1 each: busy means the frame is in progress; done is a one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD (start=1) -> FLUSH (after the N-th accepted sample) -> DONE (after the last flush advance) -> IDLE (next cycle).
REQ-014 SHALL keep a step counter k of N_LOG2+1 bits, cleared on IDLE->LOAD and incremented on every cycle with adv=1; k spans 0..2N-2.
REQ-015 SHALL drive in_ready=1 only in LOAD; adv = in_valid&in_ready in LOAD, 1 in FLUSH, 0 otherwise.
REQ-016 SHALL transition LOAD->FLUSH on the cycle in which adv=1 and k=N-1, and FLUSH->DONE on the cycle in which adv=1 and k=2N-2.
REQ-017 SHALL define, for stage s, D_s = N - 2^(N_LOG2-s) and j_s = k - D_s; the stage is active when 0 <= j_s <= N-1.
REQ-018 SHALL assert bf_en[s] = adv & active_s & bit (N_LOG2-1-s) of j_s; bf_en[s] SHALL be 0 when the stage is inactive.
REQ-019 SHALL drive tw_addr field s = (j_s mod 2^(N_LOG2-1-s)) << s when active_s, and 0 otherwise; field N_LOG2-1 SHALL always be 0.
REQ-020 SHALL assert out_valid = adv & (k >= N-1), with out_idx = bit-reverse of (k-(N-1)) on N_LOG2 bits, and out_idx = 0 when out_valid=0.
REQ-021 SHALL make all outputs combinational from registered state and k, with zero latency from the handshake to adv.
REQ-022 SHALL hold busy=1 in LOAD and FLUSH, and pulse done=1 for exactly one cycle in DONE.
REQ-023 SHALL ignore start outside IDLE; in_valid while not LOAD SHALL be ignored and SHALL NOT be acknowledged.
REQ-024 SHALL freeze k and all control outputs (adv=0) during LOAD input bubbles (in_valid=0).

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, force the state to IDLE and k to 0, including mid-frame; the partial frame is discarded.
REQ-026 SHALL hold all outputs at 0 in IDLE and during reset.

Configuration
REQ-027 SHALL, with macro FFT_CTRL_BACKPRESSURE_EN defined, add port out_ready (input, 1), AND adv in FLUSH with out_ready, and make in_ready = LOAD & (out_ready | k<N-1).
REQ-028 SHALL, with FFT_CTRL_BACKPRESSURE_EN undefined, have no out_ready port and behave as REQ-015.

Verification
REQ-029 SHALL cover N_LOG2=4, start, in_valid held at 1: in_ready high for 16 cycles, out_valid on k=15..30, out_idx 0,8,4,12,...,15, done at cycle 32 after start.
REQ-030 SHALL cover N_LOG2=4, k=9: bf_en=4'b0101? No -- it checks j_0=9, j_1=1, j_2=-3 -> bf_en[0]=1, bf_en[1]=0, bf_en[2]=0, tw_addr field0=1.
REQ-031 SHALL cover in_valid toggling 1/0 during LOAD: k and bf_en frozen on bubbles, total adv count = 31.
REQ-032 SHALL cover rst_n=0 at k=20: next cycle IDLE, busy=0, out_valid=0; a new start then runs a full clean frame.
REQ-033 SHALL cover start and in_valid asserted during FLUSH: no effect, in_ready=0, frame timing unchanged.
REQ-034 SHALL cover, with FFT_CTRL_BACKPRESSURE_EN, out_ready=0 for 3 cycles at k=18: adv=0, k held at 18, done delayed by 3 cycles.
